sb_width_down: RTL

- Synthesizable stage directly downstream of the simulation queue receiver.
- Accepts one wide switchboard packet (data/dest/last) per valid/ready handshake.
- Emits the packet as a sequence of narrower OW-bit beats on an identical valid/ready interface.
- Lets a DW-wide queue feed narrow datapaths (e.g. 64-bit buses) in the DUT.

---
 rtl/sb_pkg.sv | 16 +
 rtl/sb_width_down.sv | 90 +++++++++
 2 files changed

// File: rtl/sb_pkg.sv
// Shared switchboard packet definitions for the width converters.
// sb_pkt_t holds the per-packet header (dest and last) that travels with each payload.
package sb_pkg;

    localparam int SB_DEST_W = 32;

    typedef struct packed {
        logic [SB_DEST_W-1:0] dest;
        logic                 last;
    } sb_pkt_t;

    function automatic int sb_num_beats(input int dw, input int ow);
        return (dw + ow - 1) / ow;
    endfunction

endpackage

// File: rtl/sb_width_down.sv
// Splits one wide switchboard packet into NBEATS narrow beats, LSB slice first.
// Back-to-back packets stream with no bubble between them.
//
// state | meaning
// IDLE  | no packet held, in_ready=1, out_valid=0
// SEND  | emitting captured packet, beat_q selects the current slice
module sb_width_down
    import sb_pkg::*;
#(
    parameter int DW = 416,
    parameter int OW = 64
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [DW-1:0]        in_data,
    input  logic [SB_DEST_W-1:0] in_dest,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OW-1:0]        out_data,
    output logic [SB_DEST_W-1:0] out_dest,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int NBEATS = sb_num_beats(DW, OW);
    localparam int CW     = NBEATS * OW;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cap_q, cap_ext;
    sb_pkt_t       hdr_q;
    logic [BW-1:0] beat_q;
    logic          busy, final_beat, load, advance, drain;

    assign busy       = (state_q == SEND);
    assign final_beat = (beat_q == LAST_BEAT);
    assign in_ready   = !busy || (out_ready && final_beat);
    assign load       = in_valid && in_ready;
    assign advance    = busy && out_ready && !final_beat;
    assign drain      = busy && out_ready && final_beat && !in_valid;

    // Pad the payload so the final beat carries zeros above DW.
    always_comb begin
        cap_ext         = '0;
        cap_ext[DW-1:0] = in_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SEND;
            SEND:    if (drain)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The capture register shifts right per beat, so the live slice is always the LSBs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cap_q   <= '0;
            hdr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cap_q      <= cap_ext;
                hdr_q.dest <= in_dest;
                hdr_q.last <= in_last;
                beat_q     <= '0;
            end else if (advance) begin
                cap_q  <= cap_q >> OW;
                beat_q <= beat_q + 1'b1;
            end else if (drain) begin
                beat_q <= '0;
            end
        end
    end

    assign out_valid = busy;
    assign out_data  = cap_q[OW-1:0];
    assign out_dest  = hdr_q.dest;
    assign out_last  = busy && hdr_q.last && final_beat;

endmodule
